md_cart_responder: RTL and testbench

Cartridge-side responder for the console cartridge bus: decodes the board's cart strobes, runs one request/acknowledge transaction per bus cycle against an external ROM/SRAM store, drives read data and its enable back onto the cart data bus, and asserts `ext_dtack` once the cycle is satisfied. It also holds the TIME-region bank registers that map 512 KiB cart slots to physical store pages. It sits on the cartridge side of the board, opposite the console cart interface.

---
 rtl/md_cart_responder.sv | 196 +++++++++++++++++++
 tb/tb_md_cart_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_cart_responder.sv
// rtl/md_cart_responder.sv - cartridge-side cart bus responder with request/ack store port
// Optional TIME-region bank mapper and SRAM overlay: define MD_CART_MAPPER_EN.
module md_cart_responder #(
  parameter int MEM_AW = 24
) (
  input  logic              MCLK2,
  input  logic              ext_reset,
  input  logic [22:0]       cart_address,
  input  logic              cart_cs,
  input  logic              cart_oe,
  input  logic              cart_lwr,
  input  logic              cart_uwr,
  input  logic              cart_time,
  input  logic [15:0]       cart_data_wr,
  output logic [15:0]       cart_data,
  output logic              cart_data_en,
  output logic              ext_dtack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_sram,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              act, act_q, start_q;
  logic              is_wr;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_sram_q, mem_sram_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [MEM_AW-1:0] map_addr;
  logic              map_sram;
  logic              t_act, t_act_q, time_busy_q, time_rd_q;
  logic              slot_rd_hold;
  logic              unused_addr;

  assign is_wr       = cart_lwr | cart_uwr;
  assign act         = cart_cs & (cart_oe | is_wr);
  assign t_act       = cart_time & (cart_oe | is_wr);
  assign unused_addr = ^cart_address[22:21];

  // Start is registered twice (edge flop, then pulse) so mem_req trails act by two clocks.
  always_ff @(posedge MCLK2 or posedge ext_reset) begin
    if (ext_reset) begin
      act_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      act_q   <= act;
      start_q <= act & ~act_q;
    end
  end

`ifdef MD_CART_MAPPER_EN
  logic [2:0] slot;
  logic [5:0] bank_q [8];
  logic       sram_map_q;
  logic       tw, tw_q;

  assign slot = cart_address[20:18];
  assign tw   = cart_time & cart_lwr;

  always_ff @(posedge MCLK2 or posedge ext_reset) begin
    if (ext_reset) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= 6'(i);
      sram_map_q <= 1'b0;
      tw_q       <= 1'b0;
    end else begin
      tw_q <= tw;
      if (tw & ~tw_q) begin
        if (cart_address[2:0] == 3'd0) sram_map_q <= cart_data_wr[0];
        else bank_q[cart_address[2:0]] <= cart_data_wr[5:0];
      end
    end
  end

  always_comb begin
    map_sram = 1'b0;
    map_addr = MEM_AW'({bank_q[slot], cart_address[17:0]});
    if (sram_map_q && slot[2]) begin
      map_sram = 1'b1;
      map_addr = MEM_AW'({6'h00, cart_address[17:0]});
    end
  end
`else
  assign map_sram = 1'b0;
  assign map_addr = MEM_AW'({3'b000, cart_address[20:0]});
`endif

  // TIME cycles never touch the store; they just acknowledge until cart_time drops.
  always_ff @(posedge MCLK2 or posedge ext_reset) begin
    if (ext_reset) begin
      t_act_q     <= 1'b0;
      time_busy_q <= 1'b0;
      time_rd_q   <= 1'b0;
    end else begin
      t_act_q <= t_act;
      if (!cart_time) begin
        time_busy_q <= 1'b0;
      end else if (t_act & ~t_act_q) begin
        time_busy_q <= 1'b1;
        time_rd_q   <= ~is_wr;
      end
    end
  end

  always_ff @(posedge MCLK2 or posedge ext_reset) begin
    if (ext_reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      mem_sram_q  <= 1'b0;
      rdata_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sram_q  <= mem_sram_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sram_d  = mem_sram_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d     = S_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = is_wr;
          mem_be_d    = is_wr ? {cart_uwr, cart_lwr} : 2'b11;
          mem_addr_d  = map_addr;
          mem_wdata_d = cart_data_wr;
          mem_sram_d  = map_sram;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (act) begin
            state_d = S_HOLD;
            if (!mem_we_q) rdata_d = mem_rdata;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!act) begin
          // Console gave up early; keep the request alive so the store's ack is consumed.
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (!act) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign slot_rd_hold = (state_q == S_HOLD) & ~mem_we_q;
  assign ext_dtack    = (state_q == S_HOLD) | time_busy_q;
  assign cart_data_en = slot_rd_hold | (time_busy_q & time_rd_q);
  assign cart_data    = slot_rd_hold ? rdata_q : 16'h0000;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_be       = mem_be_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_sram     = mem_sram_q;

endmodule

// File: tb/tb_md_cart_responder.sv
// tb/tb_md_cart_responder.sv - directed self-checking bench for md_cart_responder
module tb_md_cart_responder;

  logic        clk = 1'b0;
  logic        ext_reset;
  logic [22:0] cart_address;
  logic        cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time;
  logic [15:0] cart_data_wr;
  logic [15:0] cart_data;
  logic        cart_data_en, ext_dtack;
  logic        mem_req, mem_we, mem_sram;
  logic [1:0]  mem_be;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

`ifdef MD_CART_MAPPER_EN
  localparam logic [23:0] EXP_BANK_ADDR = 24'h280004;
  localparam logic [23:0] EXP_SRAM_ADDR = 24'h000005;
  localparam logic        EXP_SRAM      = 1'b1;
`else
  localparam logic [23:0] EXP_BANK_ADDR = 24'h1C0004;
  localparam logic [23:0] EXP_SRAM_ADDR = 24'h100005;
  localparam logic        EXP_SRAM      = 1'b0;
`endif

  md_cart_responder #(.MEM_AW(24)) dut (
    .MCLK2        (clk),
    .ext_reset    (ext_reset),
    .cart_address (cart_address),
    .cart_cs      (cart_cs),
    .cart_oe      (cart_oe),
    .cart_lwr     (cart_lwr),
    .cart_uwr     (cart_uwr),
    .cart_time    (cart_time),
    .cart_data_wr (cart_data_wr),
    .cart_data    (cart_data),
    .cart_data_en (cart_data_en),
    .ext_dtack    (ext_dtack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_sram     (mem_sram),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack_pulse(input logic [15:0] rdata);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
  endtask

  initial begin
    ext_reset    = 1'b1;
    cart_address = '0;
    cart_cs      = 1'b0;
    cart_oe      = 1'b0;
    cart_lwr     = 1'b0;
    cart_uwr     = 1'b0;
    cart_time    = 1'b0;
    cart_data_wr = 16'h0000;
    mem_rdata    = 16'h0000;
    mem_ack      = 1'b0;
    tick();
    tick();
    check("rst_cart_data", cart_data, 0);
    check("rst_data_en", cart_data_en, 0);
    check("rst_dtack", ext_dtack, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_sram", mem_sram, 0);
    ext_reset = 1'b0;
    tick();

    // read with ack three cycles after the request
    cart_address = 23'h000100;
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    tick();
    check("rd_req_early", mem_req, 0);
    tick();
    check("rd_req", mem_req, 1);
    check("rd_addr", mem_addr, 24'h000100);
    check("rd_we", mem_we, 0);
    check("rd_be", mem_be, 2'b11);
    tick();
    tick();
    check("rd_dtack_before_ack", ext_dtack, 0);
    ack_pulse(16'hBEEF);
    check("rd_data", cart_data, 16'hBEEF);
    check("rd_data_en", cart_data_en, 1);
    check("rd_dtack", ext_dtack, 1);
    check("rd_req_cleared", mem_req, 0);
    tick();
    check("rd_dtack_held", ext_dtack, 1);
    cart_oe = 1'b0;
    cart_cs = 1'b0;
    tick();
    check("rd_en_release", cart_data_en, 0);
    check("rd_dtack_release", ext_dtack, 0);
    check("rd_data_release", cart_data, 0);

    // upper-byte write
    cart_address = 23'h000200;
    cart_data_wr = 16'h12FF;
    cart_cs = 1'b1;
    cart_uwr = 1'b1;
    tick();
    check("wr_en_early", cart_data_en, 0);
    tick();
    check("wr_req", mem_req, 1);
    check("wr_we", mem_we, 1);
    check("wr_be", mem_be, 2'b10);
    check("wr_wdata", mem_wdata, 16'h12FF);
    ack_pulse(16'h0000);
    check("wr_dtack", ext_dtack, 1);
    check("wr_en", cart_data_en, 0);
    cart_uwr = 1'b0;
    cart_cs = 1'b0;
    tick();
    check("wr_dtack_release", ext_dtack, 0);

    // TIME write index 7 = 0x0A
    cart_time = 1'b1;
    cart_lwr = 1'b1;
    cart_address = 23'h000007;
    cart_data_wr = 16'h000A;
    tick();
    check("tw_dtack", ext_dtack, 1);
    check("tw_no_req", mem_req, 0);
    tick();
    check("tw_no_req2", mem_req, 0);
    cart_time = 1'b0;
    cart_lwr = 1'b0;
    tick();
    check("tw_dtack_release", ext_dtack, 0);

    // read through slot 7
    cart_address = 23'h1C0004;
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    tick();
    tick();
    check("bank_addr", mem_addr, EXP_BANK_ADDR);
    check("bank_sram", mem_sram, 0);
    ack_pulse(16'h1234);
    check("bank_data", cart_data, 16'h1234);
    cart_cs = 1'b0;
    cart_oe = 1'b0;
    tick();

    // TIME read returns zero with data enable
    cart_time = 1'b1;
    cart_oe = 1'b1;
    cart_address = 23'h000000;
    tick();
    check("tr_dtack", ext_dtack, 1);
    check("tr_en", cart_data_en, 1);
    check("tr_data", cart_data, 0);
    cart_time = 1'b0;
    cart_oe = 1'b0;
    tick();
    check("tr_en_release", cart_data_en, 0);

    // enable SRAM overlay, then write slot 4 offset 5
    cart_time = 1'b1;
    cart_lwr = 1'b1;
    cart_address = 23'h000000;
    cart_data_wr = 16'h0001;
    tick();
    cart_time = 1'b0;
    cart_lwr = 1'b0;
    tick();
    cart_address = 23'h100005;
    cart_data_wr = 16'h5555;
    cart_cs = 1'b1;
    cart_lwr = 1'b1;
    tick();
    tick();
    check("sram_flag", mem_sram, EXP_SRAM);
    check("sram_addr", mem_addr, EXP_SRAM_ADDR);
    check("sram_be", mem_be, 2'b01);
    ack_pulse(16'h0000);
    cart_cs = 1'b0;
    cart_lwr = 1'b0;
    tick();

    // abort: act drops one cycle after the request, ack four cycles later
    cart_address = 23'h000300;
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    tick();
    tick();
    check("ab_req", mem_req, 1);
    tick();
    cart_cs = 1'b0;
    cart_oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_drain_req", mem_req, 1);
      check("ab_drain_dtack", ext_dtack, 0);
      check("ab_drain_en", cart_data_en, 0);
    end
    ack_pulse(16'hDEAD);
    check("ab_req_cleared", mem_req, 0);
    check("ab_dtack", ext_dtack, 0);
    check("ab_en", cart_data_en, 0);
    cart_address = 23'h000400;
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    tick();
    tick();
    check("ab_next_req", mem_req, 1);
    check("ab_next_addr", mem_addr, 24'h000400);
    ack_pulse(16'hCAFE);
    check("ab_next_data", cart_data, 16'hCAFE);
    cart_cs = 1'b0;
    cart_oe = 1'b0;
    tick();

    // remap slot 3, then reset during REQ
    cart_time = 1'b1;
    cart_lwr = 1'b1;
    cart_address = 23'h000003;
    cart_data_wr = 16'h0015;
    tick();
    cart_time = 1'b0;
    cart_lwr = 1'b0;
    tick();
    cart_address = 23'h000010;
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    tick();
    tick();
    check("rs_req_before", mem_req, 1);
    #2;
    ext_reset = 1'b1;
    #1;
    check("rs_req_async", mem_req, 0);
    check("rs_addr_async", mem_addr, 0);
    cart_cs = 1'b0;
    cart_oe = 1'b0;
    tick();
    ext_reset = 1'b0;
    ack_pulse(16'h7777);
    check("rs_stray_req", mem_req, 0);
    check("rs_stray_dtack", ext_dtack, 0);
    check("rs_stray_en", cart_data_en, 0);
    cart_address = 23'h0C0008;
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    tick();
    tick();
    check("rs_slot3_req", mem_req, 1);
    check("rs_slot3_bank", mem_addr[23:18], 6'd3);
    check("rs_slot3_addr", mem_addr, 24'h0C0008);
    ack_pulse(16'h0303);
    check("rs_slot3_data", cart_data, 16'h0303);
    cart_cs = 1'b0;
    cart_oe = 1'b0;
    tick();
    check("rs_slot3_release", ext_dtack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
